instr_word_encoder: RTL

- Inverse of the CPU's immediate-extraction path: packs decoded fields (type, registers, funct3, signed immediate) into 32-bit RV instruction words for S-type stores, I-type loads and B-type branches.
- Streams the words into instruction memory at an auto-incrementing address; used by the bench/boot loader to build programs in hardware.
- Valid/ready input, one-cycle registered write port, range checking, sticky error flags, and a run/full state machine.

---
 rtl/instr_enc_pkg.sv | 38 +++
 rtl/instr_word_encoder_imm_pack.sv | 47 ++++
 rtl/instr_word_encoder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/instr_enc_pkg.sv
// Shared constants for the instruction word encoder: opcodes, bundle type codes,
// FSM states, immediate limits and the immediate-extraction helper used by readback.
package instr_enc_pkg;

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] TYPE_S    = 2'd0;
  localparam logic [1:0] TYPE_I    = 2'd1;
  localparam logic [1:0] TYPE_B    = 2'd2;
  localparam logic [1:0] TYPE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam logic signed [31:0] IMM_SI_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_SI_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX  = 32'sd4094;

  // Recovers the sign-extended immediate from an already-encoded word.
  function automatic logic [31:0] extract_imm(input logic [31:0] word);
    logic [31:0] imm;
    imm = '0;
    case (word[6:0])
      OP_STORE:  imm = {{20{word[31]}}, word[31:25], word[11:7]};
      OP_LOAD:   imm = {{20{word[31]}}, word[31:20]};
      OP_BRANCH: imm = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
      default:   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instr_word_encoder_imm_pack.sv
// Combinational field packer: scatters the immediate into S/I/B layouts and
// reports whether the bundle is encodable (type valid, immediate in range).
module imm_pack
  import instr_enc_pkg::*;
(
  input  logic [1:0]  in_type,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        ok,
  output logic        type_err
);

  logic signed [31:0] simm;
  logic               fits_si;
  logic               fits_b;

  assign simm    = imm;
  assign fits_si = (simm >= IMM_SI_MIN) && (simm <= IMM_SI_MAX);
  // Branch offsets are in halfwords, so bit 0 must be clear to be representable.
  assign fits_b  = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX) && !imm[0];

  always_comb begin
    word     = '0;
    ok       = 1'b0;
    type_err = 1'b0;
    case (in_type)
      TYPE_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        ok   = fits_si;
      end
      TYPE_I: begin
        word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        ok   = fits_si;
      end
      TYPE_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        ok   = fits_b;
      end
      default: type_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_word_encoder.sv
// Streams encoded S/I/B instruction words into instruction memory at an
// auto-incrementing address. Optional readback self-check: ENCODER_READBACK_EN.
module instr_word_encoder
  import instr_enc_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              full,
  output logic              err_range,
  output logic              err_type
`ifdef ENCODER_READBACK_EN
  ,
  output logic              rb_mismatch
`endif
);

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W:0]   word_count_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [31:0]       wr_data_reg;
  logic              err_range_reg;
  logic              err_type_reg;

  logic [31:0]       pack_word;
  logic              pack_ok;
  logic              pack_type_err;
  logic              handshake;
  logic              do_write;

  imm_pack u_imm_pack (
    .in_type  (in_type),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .rd       (in_rd),
    .funct3   (in_funct3),
    .imm      (in_imm),
    .word     (pack_word),
    .ok       (pack_ok),
    .type_err (pack_type_err)
  );

  assign in_ready  = (state_reg == ST_RUN) && !stop;
  assign handshake = in_valid && in_ready;
  assign do_write  = handshake && pack_ok;

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (stop)
            state_next = ST_IDLE;
          else if (do_write && (ptr_reg == LAST_PTR))
            state_next = ST_FULL;
        end
        ST_FULL: if (stop) state_next = ST_IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= BASE_PTR;
      word_count_reg <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= BASE_PTR;
      wr_data_reg    <= '0;
      err_range_reg  <= 1'b0;
      err_type_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wr_en_reg <= do_write;
      // The write issued on a restart cycle still lands at the old pointer.
      if (do_write) begin
        wr_addr_reg <= ptr_reg;
        wr_data_reg <= pack_word;
      end
      if (start) begin
        ptr_reg        <= BASE_PTR;
        word_count_reg <= '0;
      end else if (do_write) begin
        ptr_reg        <= ptr_reg + 1'b1;
        word_count_reg <= word_count_reg + 1'b1;
      end
      err_range_reg <= (err_range_reg && !start) || (handshake && !pack_ok && !pack_type_err);
      err_type_reg  <= (err_type_reg && !start) || (handshake && pack_type_err);
    end
  end

`ifdef ENCODER_READBACK_EN
  logic [31:0] imm_reg;
  logic        rb_mismatch_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      imm_reg         <= '0;
      rb_mismatch_reg <= 1'b0;
    end else begin
      if (do_write)
        imm_reg <= in_imm;
      rb_mismatch_reg <= (rb_mismatch_reg && !start) ||
                         (wr_en_reg && (extract_imm(wr_data_reg) != imm_reg));
    end
  end

  assign rb_mismatch = rb_mismatch_reg;
`endif

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign word_count = word_count_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign full       = (state_reg == ST_FULL);
  assign err_range  = err_range_reg;
  assign err_type   = err_type_reg;

endmodule
